// File: rtl/mist_audio_pkg.sv
// Shared definitions for the MiST sigma-delta audio DAC.
//   sd_state_t  : soft-mute ramp states
//   LFSR_SEED   : reset value of the dither LFSR
//   LFSR_TAPS   : Galois feedback mask for taps 16,14,13,11
//   to_offset() : two's-complement to offset-binary conversion
package mist_audio_pkg;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    PLAY,
    RAMP_DOWN
  } sd_state_t;

  localparam int unsigned MAX_WIDTH = 24;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Inverting the sample MSB maps two's complement onto offset binary.
  function automatic logic [MAX_WIDTH-1:0] to_offset(input logic signed_in,
                                                     input logic [MAX_WIDTH-1:0] x,
                                                     input int unsigned width);
    logic [MAX_WIDTH-1:0] r;
    r = x;
    if (signed_in) r[width-1] = ~r[width-1];
    return r;
  endfunction

endpackage

// File: rtl/mist_sd_mod.sv
// One sigma-delta channel: sample hold, gain stage and 1st/2nd order modulator.
// Optional dither input when MIST_SD_DAC_DITHER_EN is defined.
// Ports:
//   clk_sys, reset : clock, asynchronous active-high reset
//   sample_stb     : latch u into the hold register
//   u              : offset-binary sample
//   gain           : shared ramp gain, 0..2^RAMP_BITS
//   dither         : (optional) 2-bit signed dither, -2..1
//   dout           : 1-bit modulator output
module mist_sd_mod #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ORDER     = 1,
  parameter int unsigned RAMP_BITS = 6
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 sample_stb,
  input  logic [WIDTH-1:0]     u,
  input  logic [RAMP_BITS:0]   gain,
`ifdef MIST_SD_DAC_DITHER_EN
  input  logic [1:0]           dither,
`endif
  output logic                 dout
);

  localparam int unsigned PW = WIDTH + RAMP_BITS + 2;
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]     hold;
  logic [WIDTH-1:0]     v;
  logic [WIDTH-1:0]     v_next;
  logic [WIDTH-1:0]     vm;
  logic signed [WIDTH:0] diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] gain_x;
  logic signed [PW-1:0] prod;

  // The scaled result always lies in 0..2^WIDTH-1, so adding midscale
  // modulo 2^WIDTH to the shifted product bits gives the exact value.
  always_comb begin
    diff   = $signed({1'b0, hold}) - $signed({1'b0, MID});
    diff_x = {{(RAMP_BITS+1){diff[WIDTH]}}, diff};
    gain_x = $signed({{(WIDTH+1){1'b0}}, gain});
    prod   = diff_x * gain_x;
    v_next = MID + prod[RAMP_BITS +: WIDTH];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold <= MID;
      v    <= MID;
    end else begin
      if (sample_stb) hold <= u;
      v <= v_next;
    end
  end

`ifdef MIST_SD_DAC_DITHER_EN
  logic signed [WIDTH+1:0] dsum;
  always_comb begin
    dsum = $signed({2'b00, v}) + $signed({{WIDTH{dither[1]}}, dither});
    if (dsum < 0)
      vm = '0;
    else if (dsum > $signed({2'b00, {WIDTH{1'b1}}}))
      vm = '1;
    else
      vm = dsum[WIDTH-1:0];
  end
`else
  assign vm = v;
`endif

  if (ORDER == 1) begin : g_o1
    logic [WIDTH:0] acc;
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) acc <= '0;
      else       acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, vm};
    end
    assign dout = acc[WIDTH];
  end else begin : g_o2
    localparam int unsigned IW = WIDTH + 3;
    localparam logic signed [IW+1:0] IMAX = (IW+2)'((1 << (IW-1)) - 1);
    localparam logic signed [IW+1:0] IMIN = -IMAX - 1;
    localparam logic signed [IW+1:0] FB1  = (IW+2)'((1 << WIDTH) - 1);

    logic signed [IW-1:0] i1, i2, i1_n, i2_n;
    logic signed [IW+1:0] fb, s1, s2;
    logic                 q;

    function automatic logic signed [IW-1:0] sat(input logic signed [IW+1:0] x);
      if (x > IMAX) return IMAX[IW-1:0];
      if (x < IMIN) return IMIN[IW-1:0];
      return x[IW-1:0];
    endfunction

    // Second integrator takes the freshly updated first integrator,
    // giving NTF = (1 - z^-1)^2 with the registered decision.
    always_comb begin
      fb   = q ? FB1 : '0;
      s1   = (IW+2)'(i1) + $signed({2'b00, {(IW-WIDTH){1'b0}}, vm}) - fb;
      i1_n = sat(s1);
      s2   = (IW+2)'(i2) + (IW+2)'(i1_n) - fb;
      i2_n = sat(s2);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        i1 <= '0;
        i2 <= '0;
        q  <= 1'b0;
      end else begin
        i1 <= i1_n;
        i2 <= i2_n;
        q  <= ~i2_n[IW-1];
      end
    end
    assign dout = q;
  end

endmodule

// File: rtl/mist_sd_dac.sv
// Multi-channel sigma-delta audio DAC with click-free soft-mute ramp.
// Optional feature macro: MIST_SD_DAC_DITHER_EN (LFSR dither before modulators).
// Ports:
//   clk_sys    : system clock, modulators run every cycle
//   reset      : asynchronous, active-high
//   sample_stb : latch din, advance mute ramp
//   din        : CHANNELS*WIDTH packed samples, channel 0 in LSBs
//   mute_req   : 1 = ramp to silence, 0 = ramp to play
//   dout       : 1-bit output per channel
//   muted      : high in MUTED
//   ramp_busy  : high in RAMP_UP / RAMP_DOWN
module mist_sd_dac
  import mist_audio_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ORDER     = 1,
  parameter int unsigned SIGNED_IN = 1,
  parameter int unsigned RAMP_BITS = 6
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      sample_stb,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mute_req,
  output logic [CHANNELS-1:0]       dout,
  output logic                      muted,
  output logic                      ramp_busy
);

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("mist_sd_dac: ORDER must be 1 or 2");
  end
  if (WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mist_sd_dac: WIDTH must be 8..24");
  end

  localparam logic [RAMP_BITS:0] GMAX = {1'b1, {RAMP_BITS{1'b0}}};

  sd_state_t          state, nxt_dir, nxt_state;
  logic [RAMP_BITS:0] gain, gain_n;

  // Direction is resolved first so a strobe coinciding with a transition
  // steps the gain in the new state's direction.
  always_comb begin
    nxt_dir = state;
    case (state)
      MUTED:     if (!mute_req) nxt_dir = RAMP_UP;
      RAMP_UP:   if (mute_req)  nxt_dir = RAMP_DOWN;
      PLAY:      if (mute_req)  nxt_dir = RAMP_DOWN;
      RAMP_DOWN: if (!mute_req) nxt_dir = RAMP_UP;
      default:   nxt_dir = MUTED;
    endcase

    gain_n = gain;
    if (sample_stb) begin
      if (nxt_dir == RAMP_UP && gain != GMAX)
        gain_n = gain + 1'b1;
      else if (nxt_dir == RAMP_DOWN && gain != '0)
        gain_n = gain - 1'b1;
    end

    nxt_state = nxt_dir;
    if (nxt_dir == RAMP_UP && gain_n == GMAX)
      nxt_state = PLAY;
    else if (nxt_dir == RAMP_DOWN && gain_n == '0)
      nxt_state = MUTED;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= MUTED;
      gain      <= '0;
      muted     <= 1'b1;
      ramp_busy <= 1'b0;
    end else begin
      state     <= nxt_state;
      gain      <= gain_n;
      muted     <= (nxt_state == MUTED);
      ramp_busy <= (nxt_state == RAMP_UP) || (nxt_state == RAMP_DOWN);
    end
  end

`ifdef MIST_SD_DAC_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [MAX_WIDTH-1:0] off;
    assign off = to_offset(SIGNED_IN != 0, MAX_WIDTH'(din[c*WIDTH +: WIDTH]), WIDTH);

`ifdef MIST_SD_DAC_DITHER_EN
    logic [15:0] rot;
    assign rot = (lfsr >> (c % 16)) | (lfsr << ((16 - (c % 16)) % 16));
`endif

    mist_sd_mod #(
      .WIDTH     (WIDTH),
      .ORDER     (ORDER),
      .RAMP_BITS (RAMP_BITS)
    ) u_mod (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .sample_stb (sample_stb),
      .u          (off[WIDTH-1:0]),
      .gain       (gain),
`ifdef MIST_SD_DAC_DITHER_EN
      .dither     (rot[1:0]),
`endif
      .dout       (dout[c])
    );
  end

endmodule

// File: tb/tb_mist_sd_dac.sv
module tb_mist_sd_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // A: 8-bit, 1st order, unsigned, 4-step ramp
  logic       stb_a, mute_a;
  logic [7:0] din_a;
  logic [0:0] dout_a;
  logic       muted_a, busy_a;
  // B: 2 channels, 8-bit, 1st order, signed, 4-step ramp
  logic        stb_b, mute_b;
  logic [15:0] din_b;
  logic [1:0]  dout_b;
  logic        muted_b, busy_b;
  // C: 8-bit, 1st order, unsigned, 8-step ramp
  logic       stb_c, mute_c;
  logic [7:0] din_c;
  logic [0:0] dout_c;
  logic       muted_c, busy_c;
  // D: 12-bit, 2nd order, unsigned, 4-step ramp
  logic        stb_d, mute_d;
  logic [11:0] din_d;
  logic [0:0]  dout_d;
  logic        muted_d, busy_d;

  mist_sd_dac #(.CHANNELS(1), .WIDTH(8), .ORDER(1), .SIGNED_IN(0), .RAMP_BITS(2)) dut_a (
    .clk_sys(clk), .reset(reset), .sample_stb(stb_a), .din(din_a), .mute_req(mute_a),
    .dout(dout_a), .muted(muted_a), .ramp_busy(busy_a));
  mist_sd_dac #(.CHANNELS(2), .WIDTH(8), .ORDER(1), .SIGNED_IN(1), .RAMP_BITS(2)) dut_b (
    .clk_sys(clk), .reset(reset), .sample_stb(stb_b), .din(din_b), .mute_req(mute_b),
    .dout(dout_b), .muted(muted_b), .ramp_busy(busy_b));
  mist_sd_dac #(.CHANNELS(1), .WIDTH(8), .ORDER(1), .SIGNED_IN(0), .RAMP_BITS(3)) dut_c (
    .clk_sys(clk), .reset(reset), .sample_stb(stb_c), .din(din_c), .mute_req(mute_c),
    .dout(dout_c), .muted(muted_c), .ramp_busy(busy_c));
  mist_sd_dac #(.CHANNELS(1), .WIDTH(12), .ORDER(2), .SIGNED_IN(0), .RAMP_BITS(2)) dut_d (
    .clk_sys(clk), .reset(reset), .sample_stb(stb_d), .din(din_d), .mute_req(mute_d),
    .dout(dout_d), .muted(muted_d), .ramp_busy(busy_d));

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];

  task automatic pulse(input int sel, input int settle);
    @(negedge clk);
    case (sel)
      0: stb_a = 1'b1;
      1: stb_b = 1'b1;
      2: stb_c = 1'b1;
      default: stb_d = 1'b1;
    endcase
    @(negedge clk);
    stb_a = 1'b0; stb_b = 1'b0; stb_c = 1'b0; stb_d = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic count_ones(input int sel, input int ncyc, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (ncyc) begin
      @(negedge clk);
      case (sel)
        0: c0 += int'(dout_a[0]);
        1: begin c0 += int'(dout_b[0]); c1 += int'(dout_b[1]); end
        2: c0 += int'(dout_c[0]);
        default: c0 += int'(dout_d[0]);
      endcase
    end
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if (dout_a !== 1'b0 || muted_a !== 1'b1 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: dout=%b muted=%b busy=%b, want 0 1 0", dout_a, muted_a, busy_a);
    end
    n_vec++;
    if (dout_b !== 2'b00 || muted_b !== 1'b1 || muted_c !== 1'b1 || muted_d !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_bcd: dout_b=%b muted=%b%b%b, want 00 111", dout_b, muted_b, muted_c, muted_d);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ramp_up;
    int e;
    din_a = 8'h40;
    mute_a = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy_a !== 1'b1 || muted_a !== 1'b0) begin
      n_bad++;
      $display("FAIL ramp_up_start: busy=%b muted=%b, want 1 0", busy_a, muted_a);
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back((k < 4) ? 1 : 0);
      pulse(0, 0);
      e = exp_q.pop_front();
      n_vec++;
      if (busy_a !== 1'(e)) begin
        n_bad++;
        $display("FAIL ramp_up_busy strobe %0d: busy=%b, want %0d", k, busy_a, e);
      end
    end
    n_vec++;
    if (muted_a !== 1'b0) begin
      n_bad++;
      $display("FAIL ramp_up_play: muted=%b, want 0", muted_a);
    end
  endtask

  task automatic test_duty_first_order;
    logic [7:0] pats[5] = '{8'h40, 8'h00, 8'hFF, 8'h01, 8'hC3};
    int c0, c1, e;
    foreach (pats[i]) begin
      din_a = pats[i];
      exp_q.push_back(int'(pats[i]));
      exp_q.push_back(int'(pats[i]));
      pulse(0, 2);
      for (int w = 0; w < 2; w++) begin
        count_ones(0, 256, c0, c1);
        e = exp_q.pop_front();
        n_vec++;
        if (c0 !== e) begin
          n_bad++;
          $display("FAIL duty_o1 din=%h win%0d: ones=%0d, want %0d", pats[i], w, c0, e);
        end
      end
    end
  endtask

  task automatic test_signed;
    logic [15:0] pats[2] = '{16'h0080, 16'hC07F};
    int exp0[2] = '{0, 255};
    int exp1[2] = '{128, 64};
    int c0, c1, e0, e1;
    mute_b = 1'b0;
    @(negedge clk);
    repeat (4) pulse(1, 0);
    foreach (pats[i]) begin
      din_b = pats[i];
      exp_q.push_back(exp0[i]);
      exp_q.push_back(exp1[i]);
      pulse(1, 2);
      count_ones(1, 256, c0, c1);
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      n_vec++;
      if (c0 !== e0) begin
        n_bad++;
        $display("FAIL signed_ch0 din=%h: ones=%0d, want %0d", pats[i], c0, e0);
      end
      n_vec++;
      if (c1 !== e1) begin
        n_bad++;
        $display("FAIL signed_ch1 din=%h: ones=%0d, want %0d", pats[i], c1, e1);
      end
    end
  endtask

  function automatic int v_ramp(input int g);
    return 128 + (127 * g) / 8;
  endfunction

  task automatic ramp_step(input int g);
    int c0, c1, e;
    exp_q.push_back(v_ramp(g));
    pulse(2, 2);
    count_ones(2, 256, c0, c1);
    e = exp_q.pop_front();
    n_vec++;
    if (c0 !== e) begin
      n_bad++;
      $display("FAIL ramp_rev gain=%0d: ones=%0d, want %0d", g, c0, e);
    end
  endtask

  task automatic test_ramp_reversal;
    int gseq[10] = '{1, 2, 3, 4, 5, 4, 3, 4, 5, 6};
    din_c = 8'hFF;
    ramp_step(0);
    mute_c = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin mute_c = 1'b1; @(negedge clk); end
      if (i == 7) begin mute_c = 1'b0; @(negedge clk); end
      ramp_step(gseq[i]);
    end
    ramp_step(7);
    ramp_step(8);
    n_vec++;
    if (muted_c !== 1'b0 || busy_c !== 1'b0) begin
      n_bad++;
      $display("FAIL ramp_rev_play: muted=%b busy=%b, want 0 0", muted_c, busy_c);
    end
  endtask

  task automatic test_second_order;
    int c0, c1, e;
    din_d = 12'd1024;
    mute_d = 1'b0;
    @(negedge clk);
    repeat (4) pulse(3, 0);
    repeat (64) @(negedge clk);
    exp_q.push_back(16384);
    count_ones(3, 65536, c0, c1);
    e = exp_q.pop_front();
    n_vec++;
    if (c0 < e - 131 || c0 > e + 131) begin
      n_bad++;
      $display("FAIL order2_density: ones=%0d, want %0d +/-131", c0, e);
    end
  endtask

  task automatic test_reset_midrun;
    int c0, c1, e;
    din_a = 8'hFF;
    pulse(0, 4);
    mute_c = 1'b1;
    pulse(2, 0);
    n_vec++;
    if (busy_c !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_pre: busy_c=%b, want 1", busy_c);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (dout_a !== 1'b0 || muted_a !== 1'b1 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_a: dout=%b muted=%b busy=%b, want 0 1 0", dout_a, muted_a, busy_a);
    end
    n_vec++;
    if (muted_c !== 1'b1 || busy_c !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_c: muted=%b busy=%b, want 1 0", muted_c, busy_c);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(128);
    pulse(2, 2);
    count_ones(2, 256, c0, c1);
    e = exp_q.pop_front();
    n_vec++;
    if (c0 !== e) begin
      n_bad++;
      $display("FAIL midrun_gain0: ones=%0d, want %0d", c0, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    stb_a = 1'b0; stb_b = 1'b0; stb_c = 1'b0; stb_d = 1'b0;
    mute_a = 1'b1; mute_b = 1'b1; mute_c = 1'b1; mute_d = 1'b1;
    din_a = '0; din_b = '0; din_c = '0; din_d = '0;
    test_reset;
    test_ramp_up;
    test_duty_first_order;
    test_signed;
    test_ramp_reversal;
    test_second_order;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
